// File: rtl/s_cntr_down.sv
// s_cntr_down -- loadable, parameterised down-counter / interval timer.
//
// Loads a start value and decrements on each enabled clock while running.
// On the 1->0 step it pulses Tc for one cycle, then either stops in DONE
// (one-shot, Mode=0) or reloads the last loaded value and keeps running
// (auto-reload, Mode=1). Per-cycle priority is Pre > Ld > count.
//
// Optional feature: define CNTR_DOWN_PRESCALE_EN to build a prescaler so
// that only every PRESCALE-th enabled RUN cycle decrements.
//
// Parameters:
//   WIDTH    counter / load width, 2..16
//   PRESCALE enabled-cycle divide ratio, 1..256 (prescaler build only)
// Ports:
//   Clk   rising-edge clock
//   rst   asynchronous active-low reset
//   T     count enable
//   Ld    synchronous load of Din (also captured as the reload value)
//   Din   load value
//   Pre   synchronous preset to all-ones (also captured as reload value)
//   Mode  0 = one-shot, 1 = auto-reload; looked at only on terminal count
//   Out   current count (registered)
//   Tc    one-cycle terminal-count pulse (registered)
//   Busy  state == RUN
//   Done  state == DONE
module s_cntr_down #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic             T,
  input  logic             Ld,
  input  logic [WIDTH-1:0] Din,
  input  logic             Pre,
  input  logic             Mode,
  output logic [WIDTH-1:0] Out,
  output logic             Tc,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Elaboration-time guard on the legal parameter ranges.
  if (WIDTH < 2 || WIDTH > 16 || PRESCALE < 1 || PRESCALE > 256) begin : g_param_chk
    $error("s_cntr_down: parameter out of range");
  end

  state_e           st_q, st_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] rld_q, rld_d;
  logic             tc_q, tc_d;
  logic             step;   // this cycle counts as one decrement/terminal step

`ifdef CNTR_DOWN_PRESCALE_EN
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PS_W-1:0] ps_q, ps_d;
  logic            ps_tick;

  // Counts enabled RUN cycles 0..PRESCALE-1; the last one is the step.
  // Wrapping to 0 on the step also covers the clear on a terminal event.
  assign ps_tick = (ps_q == PS_W'(PRESCALE - 1));
  assign step    = (st_q == ST_RUN) && T && ps_tick;

  always_comb begin
    ps_d = ps_q;
    if (Pre || Ld)
      ps_d = '0;
    else if (st_q == ST_RUN && T)
      ps_d = ps_tick ? '0 : ps_q + 1'b1;
  end

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) ps_q <= '0;
    else      ps_q <= ps_d;
  end
`else
  assign step = (st_q == ST_RUN) && T;
`endif

  always_comb begin
    st_d  = st_q;
    out_d = out_q;
    rld_d = rld_q;
    tc_d  = 1'b0;
    if (Pre) begin
      out_d = '1;
      rld_d = '1;
      st_d  = ST_RUN;
    end else if (Ld) begin
      // A zero load has nothing to count: park in IDLE without a Tc.
      out_d = Din;
      rld_d = Din;
      st_d  = (Din != '0) ? ST_RUN : ST_IDLE;
    end else if (step) begin
      if (out_q == WIDTH'(1)) begin
        tc_d = 1'b1;
        if (Mode) begin
          out_d = rld_q;
        end else begin
          out_d = '0;
          st_d  = ST_DONE;
        end
      end else if (out_q != '0) begin
        // RUN with zero is unreachable; the guard just keeps it from wrapping.
        out_d = out_q - 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      st_q  <= ST_IDLE;
      out_q <= '0;
      rld_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      st_q  <= st_d;
      out_q <= out_d;
      rld_q <= rld_d;
      tc_q  <= tc_d;
    end
  end

  assign Out  = out_q;
  assign Tc   = tc_q;
  assign Busy = (st_q == ST_RUN);
  assign Done = (st_q == ST_DONE);

endmodule

// File: tb/tb_s_cntr_down.sv
module tb_s_cntr_down;
  logic       Clk = 1'b0;
  logic       rst = 1'b0;
  logic       T = 1'b0, Ld = 1'b0, Pre = 1'b0, Mode = 1'b0;
  logic [3:0] Din = 4'd0;
  logic [3:0] Out;
  logic       Tc, Busy, Done;
  int         errors = 0;
  int         checks = 0;

  s_cntr_down #(.WIDTH(4), .PRESCALE(4)) dut (
    .Clk(Clk), .rst(rst), .T(T), .Ld(Ld), .Din(Din), .Pre(Pre), .Mode(Mode),
    .Out(Out), .Tc(Tc), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  // Advance one rising edge and settle; inputs change right after this.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (Out !== 4'd0) begin errors++; $display("FAIL reset_out got=%0d exp=0", Out); end
    checks++; if (Tc !== 1'b0) begin errors++; $display("FAIL reset_tc got=%b exp=0", Tc); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", Done); end
    tick(); rst = 1'b1;
    Ld = 1'b1; Din = 4'd9; tick();
    Ld = 1'b0; T = 1'b1;
    checks++; if (Out !== 4'd9) begin errors++; $display("FAIL reset_load got=%0d exp=9", Out); end
    repeat (3) tick();
    checks++; if (Out !== 4'd6) begin errors++; $display("FAIL reset_midcount got=%0d exp=6", Out); end
    #2 rst = 1'b0;  // asynchronous, away from any edge
    #1;
    checks++; if (Out !== 4'd0 || Busy !== 1'b0 || Done !== 1'b0 || Tc !== 1'b0) begin
      errors++; $display("FAIL reset_async got out=%0d busy=%b done=%b tc=%b exp 0/0/0/0", Out, Busy, Done, Tc);
    end
    T = 1'b0;
    tick(); rst = 1'b1;
  endtask

  task automatic test_oneshot();
    logic [3:0] exp_out [4];
    exp_out = '{4'd3, 4'd2, 4'd1, 4'd0};
    Mode = 1'b0; Ld = 1'b1; Din = 4'd3; T = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); Ld = 1'b0;
      checks++; if (Out !== exp_out[i] || Tc !== (i == 3)) begin
        errors++; $display("FAIL oneshot_%0d got out=%0d tc=%b exp out=%0d tc=%b", i, Out, Tc, exp_out[i], (i == 3));
      end
    end
    checks++; if (Done !== 1'b1 || Busy !== 1'b0) begin
      errors++; $display("FAIL oneshot_done got done=%b busy=%b exp 1/0", Done, Busy);
    end
    tick();
    checks++; if (Out !== 4'd0 || Tc !== 1'b0 || Done !== 1'b1) begin
      errors++; $display("FAIL oneshot_hold got out=%0d tc=%b done=%b exp 0/0/1", Out, Tc, Done);
    end
  endtask

  task automatic test_autoreload();
    logic [3:0] exp_out [6];
    logic       exp_tc  [6];
    exp_out = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd1, 4'd2};
    exp_tc  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    Mode = 1'b1; Ld = 1'b1; Din = 4'd2; T = 1'b1;
    tick(); Ld = 1'b0;
    checks++; if (Out !== 4'd2 || Busy !== 1'b1) begin
      errors++; $display("FAIL reload_load got out=%0d busy=%b exp 2/1", Out, Busy);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (Out !== exp_out[i] || Tc !== exp_tc[i] || Busy !== 1'b1) begin
        errors++; $display("FAIL reload_%0d got out=%0d tc=%b busy=%b exp out=%0d tc=%b busy=1",
                           i, Out, Tc, Busy, exp_out[i], exp_tc[i]);
      end
    end
    T = 1'b0;
  endtask

  task automatic test_priority();
    logic [3:0] exp_out [3];
    logic       t_seq   [3];
    exp_out = '{4'd14, 4'd14, 4'd13};
    t_seq   = '{1'b1, 1'b0, 1'b1};
    Mode = 1'b0; Pre = 1'b1; tick(); Pre = 1'b0;
    checks++; if (Out !== 4'd15 || Busy !== 1'b1) begin
      errors++; $display("FAIL prio_preset got out=%0d busy=%b exp 15/1", Out, Busy);
    end
    for (int i = 0; i < 3; i++) begin
      T = t_seq[i]; tick();
      checks++; if (Out !== exp_out[i]) begin
        errors++; $display("FAIL prio_gate_%0d got=%0d exp=%0d", i, Out, exp_out[i]);
      end
    end
    T = 1'b0; Pre = 1'b1; Ld = 1'b1; Din = 4'd7; tick(); Pre = 1'b0; Ld = 1'b0;
    checks++; if (Out !== 4'd15) begin errors++; $display("FAIL prio_pre_over_ld got=%0d exp=15", Out); end
  endtask

  task automatic test_collision();
    Mode = 1'b0; Ld = 1'b1; Din = 4'd1; tick();
    checks++; if (Out !== 4'd1) begin errors++; $display("FAIL coll_setup got=%0d exp=1", Out); end
    T = 1'b1; Ld = 1'b1; Din = 4'd5; tick();
    checks++; if (Out !== 4'd5 || Tc !== 1'b0 || Busy !== 1'b1 || Done !== 1'b0) begin
      errors++; $display("FAIL coll_ld_wins got out=%0d tc=%b busy=%b done=%b exp 5/0/1/0", Out, Tc, Busy, Done);
    end
    Din = 4'd0; tick(); Ld = 1'b0;
    checks++; if (Out !== 4'd0 || Tc !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) begin
      errors++; $display("FAIL coll_ld_zero got out=%0d tc=%b busy=%b done=%b exp 0/0/0/0", Out, Tc, Busy, Done);
    end
    tick();
    checks++; if (Out !== 4'd0 || Tc !== 1'b0 || Busy !== 1'b0) begin
      errors++; $display("FAIL coll_idle_hold got out=%0d tc=%b busy=%b exp 0/0/0", Out, Tc, Busy);
    end
    T = 1'b0;
  endtask

`ifdef CNTR_DOWN_PRESCALE_EN
  task automatic test_prescale();
    Mode = 1'b0; Ld = 1'b1; Din = 4'd2; tick(); Ld = 1'b0; T = 1'b1;
    repeat (3) tick();
    checks++; if (Out !== 4'd2) begin errors++; $display("FAIL ps_3 got=%0d exp=2", Out); end
    tick();
    checks++; if (Out !== 4'd1) begin errors++; $display("FAIL ps_4 got=%0d exp=1", Out); end
    repeat (3) tick();
    checks++; if (Out !== 4'd1 || Tc !== 1'b0) begin
      errors++; $display("FAIL ps_7 got out=%0d tc=%b exp 1/0", Out, Tc);
    end
    tick();
    checks++; if (Out !== 4'd0 || Tc !== 1'b1 || Done !== 1'b1) begin
      errors++; $display("FAIL ps_8 got out=%0d tc=%b done=%b exp 0/1/1", Out, Tc, Done);
    end
    T = 1'b0;
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_oneshot();
    test_autoreload();
    test_priority();
    test_collision();
`ifdef CNTR_DOWN_PRESCALE_EN
    test_prescale();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/s_cntr_down.md
Name: s_cntr_down

Overview:
- Synchronous, loadable, parameterised down-counter/timer. It is the count-down companion to the existing up-counter.
- Loads a start value and decrements on each enabled clock. On the 1->0 transition it flags terminal count, then either stops (one-shot) or reloads (auto-reload).
- Used as a delay/interval timer and event down-counter alongside the up-counter in the lab designs.

Parameters:
- WIDTH, 4, counter and load-value width in bits (legal range 2..16).
- PRESCALE, 4, enabled-cycle divide ratio. Used only when CNTR_DOWN_PRESCALE_EN is defined; legal range 1..256.

Ports:
- Clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- T  input  1  count enable; decrement permitted when high
- Ld  input  1  synchronous load strobe
- Din  input  WIDTH  load value, sampled when Ld=1
- Pre  input  1  synchronous preset: load all-ones
- Mode  input  1  0 = one-shot, 1 = auto-reload
- Out  output  WIDTH  current count (registered)
- Tc  output  1  terminal-count pulse, one cycle, registered
- Busy  output  1  high while in RUN
- Done  output  1  high while in DONE (one-shot expired)

Behaviour:
- Reset (rst=0, asynchronous, any time including mid-count):
  - Out=0, Tc=0, Busy=0, Done=0, state=IDLE, reload register=0, prescaler=0.
  - Release is synchronous to the next Clk edge.
- States: IDLE, RUN, DONE. Busy=(state==RUN); Done=(state==DONE).
- Per-cycle priority: Pre > Ld > count. Tc defaults to 0 every cycle.
- Pre=1, any state: Out<=all-ones, reload<=all-ones, state->RUN.
- Ld=1 (Pre=0), any state: Out<=Din, reload<=Din.
  - Din!=0: state->RUN.
  - Din==0: state->IDLE, no Tc.
- RUN, T=1, Out>1: Out<=Out-1.
- RUN, T=1, Out==1 (terminal event): Tc<=1 in the same edge in which Out changes.
  - Mode=0: Out<=0, state->DONE.
  - Mode=1: Out<=reload, stay RUN.
  - Mode is sampled only at the terminal event.
- RUN, T=0: hold.
- IDLE/DONE: Out holds, T ignored. Exit only via Pre or Ld.
- Out never wraps below 0 and never underflows; RUN with Out==0 is unreachable.
- Ld or Pre in the same cycle as a terminal event: load wins, no Tc, no DONE.
- Latency: Out and Tc reflect an input one Clk edge after it is sampled.
- Auto-reload period: reload enabled cycles per Tc pulse (e.g. reload=5 gives Tc every 5th enabled cycle).

Optional Feature:
- Macro: CNTR_DOWN_PRESCALE_EN.
- Defined:
  - An internal prescaler counts RUN cycles with T=1.
  - A decrement or terminal event occurs only on every PRESCALE-th such cycle.
  - The prescaler clears on reset, Ld, Pre and each terminal event.
  - PRESCALE=1 is equivalent to the feature being off.
- Undefined: every RUN cycle with T=1 decrements; PRESCALE is ignored and no prescaler logic is built.

Test Plan:
1. Reset mid-count: Ld Din=9, 3 enabled cycles (Out=6), then assert rst -> Out=0, Busy=0, Done=0, Tc=0 immediately, without a clock edge.
2. One-shot: Mode=0, Ld Din=3, T=1 continuously -> Out 3,2,1,0 on successive edges; Tc=1 only on the edge Out becomes 0; Done=1 and Busy=0 thereafter; Out stays 0 with T=1.
3. Auto-reload: Mode=1, Ld Din=2, T=1 for 7 cycles -> Out 2,1,2,1,2,1,2; Tc high on cycles 2, 4, 6; Busy stays 1.
4. Enable gating and priority: Pre=1 -> Out=15 (WIDTH=4); T toggled 1,0,1 -> Out 14,14,13. Ld Din=7 with Pre=1 in the same cycle -> Out=15.
5. Load collision: Out=1, T=1, Ld Din=5 in the same cycle -> Out=5, Tc=0, state RUN. Separately, Ld Din=0 -> Out=0, IDLE, Tc never asserted.
6. CNTR_DOWN_PRESCALE_EN, PRESCALE=4: Ld Din=2, T=1 -> Out=1 after 4 enabled cycles, Out=0 with Tc after 8, Done=1.
